// File: rtl/lcu_keyed_ring.sv
// Key-gated ring sequencer: locked stages enter a genuine or decoy copy by key bit, all on negedge.
// Optional LCU_KEYED_CORRUPT_EN blanks y in decoy stages once the decoy entry count reaches LIMIT.
module lcu_keyed_ring #(
    parameter int unsigned      STAGES  = 8,
    parameter int unsigned      KEY_W   = 4,
    parameter logic [KEY_W-1:0] KEY_VAL = 4'b1010,
    parameter int unsigned      LIMIT   = 5,
    parameter int unsigned      CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       adv,
    input  logic                       back,
    input  logic [KEY_W-1:0]           key,
    output logic [STAGES-1:0]          y,
    output logic                       wrap_o,
    output logic [$clog2(STAGES)-1:0]  stage_o,
    output logic                       decoy_o,
    output logic [CNT_W-1:0]           dcnt_o
);

    localparam int unsigned      SW      = $clog2(STAGES);
    localparam logic [SW-1:0]    LAST    = SW'(STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIM     = CNT_W'(LIMIT);

    logic [SW-1:0]    stage_q, stage_d, stage_nxt;
    logic             decoy_q, decoy_d, entry_decoy;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [KEY_W-1:0] key_mis;

    assign key_mis = key ^ KEY_VAL;

    always_comb begin
        stage_nxt   = (stage_q == LAST) ? '0 : stage_q + SW'(1);
        // Only S1..S(KEY_W) have a decoy copy; the key bit is used solely on entry.
        entry_decoy = 1'b0;
        for (int k = 0; k < int'(KEY_W); k++) begin
            if (stage_nxt == SW'(k + 1)) entry_decoy = key_mis[k];
        end

        stage_d = stage_q;
        decoy_d = decoy_q;
        wrap_d  = 1'b0;
        dcnt_d  = dcnt_q;
        if (back) begin
            stage_d = '0;
            decoy_d = 1'b0;
        end else if (adv) begin
            stage_d = stage_nxt;
            decoy_d = entry_decoy;
            wrap_d  = (stage_q == LAST);
            // adv always changes stage, so every decoy entry counts.
            if (entry_decoy && dcnt_q != CNT_MAX) dcnt_d = dcnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            decoy_q <= 1'b0;
            wrap_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            stage_q <= stage_d;
            decoy_q <= decoy_d;
            wrap_q  <= wrap_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        y          = '0;
        y[stage_q] = 1'b1;
`ifdef LCU_KEYED_CORRUPT_EN
        if (decoy_q && dcnt_q >= LIM) y = '0;
`endif
    end

    assign wrap_o  = wrap_q;
    assign stage_o = stage_q;
    assign decoy_o = decoy_q;
    assign dcnt_o  = dcnt_q;

endmodule

// File: doc/lcu_keyed_ring.md
# lcu_keyed_ring

Parametrised key-gated sequence controller, next generation of the single-key LCU locking benchmark. Walks a ring of `STAGES` Moore states. Each of the first `KEY_W` non-zero stages has a genuine copy and a decoy copy, and a per-stage key bit selects between them. A saturating decoy-entry counter corrupts decoy outputs once a visit limit is reached. Used as a locking/obfuscation benchmark core in the same flow as the LCU benchmarks.

## Interface
- `STAGES`, 8, number of ring stages S0..S(STAGES-1); legal 2..32.
- `KEY_W`, 4, number of locked stages (S1..S(KEY_W)); legal 1..STAGES-1.
- `KEY_VAL`, 4'b1010, correct key, `KEY_W` bits.
- `LIMIT`, 5, decoy entry count at which corruption starts; legal 1..2^CNT_W-1.
- `CNT_W`, 4, width of the decoy counter.

Ports:
- `clk`  in  1  clock; all state updates on the falling edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `adv`  in  1  advance request, sampled at the falling edge.
- `back`  in  1  abort to S0, sampled at the falling edge; has priority over `adv`.
- `key`  in  KEY_W  key vector; sampled only on the edge that enters a locked stage.
- `y`  out  STAGES  one-hot stage output (Moore).
- `wrap_o`  out  1  registered one-cycle pulse when the ring wraps from S(STAGES-1) to S0.
- `stage_o`  out  $clog2(STAGES)  current stage index.
- `decoy_o`  out  1  high while in a decoy copy.
- `dcnt_o`  out  CNT_W  decoy entry count.

## Operation
- State is {stage index, decoy bit}, giving STAGES+KEY_W reachable states.
- Next state, evaluated in priority order:
  - `back`=1 → S0 genuine.
  - `adv`=1 → stage j=(i+1) mod STAGES.
  - otherwise hold, including the decoy bit.
- On an `adv` entry to j:
  - If 1≤j≤KEY_W: decoy = (`key[j-1]` != `KEY_VAL[j-1]`).
  - Otherwise: decoy = 0.
- A decoy copy has exactly the same transition behaviour as its genuine copy.
- `dcnt_o` increments by 1 on every edge that enters a decoy state from a different state.
  - Holding in a decoy state does not count.
  - Saturates at 2^CNT_W-1.
  - Cleared only by `rst`.
- `y`:
  - Default: one-hot of the stage index, `y[i]`=1.
  - Corrupted case: decoy_o=1 and `dcnt_o` ≥ `LIMIT` → `y`=0.
- `wrap_o` is 1 for the single cycle after an `adv` edge from S(STAGES-1) to S0. A `back` to S0 does not pulse it.
- Reset values:
  - State S0 genuine.
  - `y`=one-hot bit 0.
  - `stage_o`=0, `decoy_o`=0, `dcnt_o`=0, `wrap_o`=0.

## Timing
- All registers update on the negedge of `clk`.
- `y`, `stage_o` and `decoy_o` are decoded from registered state. They are valid one edge after `adv`/`back` is sampled.
- `dcnt_o` updates on the same edge as the decoy entry. `y` corruption therefore applies already on the entry that reaches `LIMIT`.
- `rst` asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge. The first transition occurs on the first falling edge after deassertion.
- `adv` and `back` both 1: `back` wins, no wrap pulse, no count.
- Key changes while holding in a stage have no effect.
- Entering S1 from S0 via `adv`, when S0 was itself reached by wrap, is an ordinary locked entry.

## Configuration
- `LCU_KEYED_CORRUPT_EN`:
  - Defined: the `y`=0 corruption rule is active.
  - Undefined: decoy states drive the normal one-hot `y`. The counter and `decoy_o` still operate identically, so corruption is the only difference.

## Test plan
All scenarios use default parameters.
- Reset: assert `rst` → `y`=8'h01, `stage_o`=0, `decoy_o`=0, `dcnt_o`=0, `wrap_o`=0.
- Correct key: `key`=4'b1010, 8 `adv` edges.
  - `y` walks 01,02,04,08,10,20,40,80,01.
  - `wrap_o`=1 for exactly one cycle after the 8th edge.
  - `decoy_o` stays 0 and `dcnt_o` stays 0.
- Wrong key bit 0: `key`=4'b1011, 1 `adv` → `stage_o`=1, `decoy_o`=1, `dcnt_o`=1, `y`=8'h02. A held `adv`=0 for 3 cycles leaves `dcnt_o`=1.
- Corruption: `key`=4'b1011, cycle the full ring 5 times.
  - Entries 1–4 into S1 give `y`=8'h02.
  - Entry 5 gives `dcnt_o`=5, `y`=8'h00 with the macro, 8'h02 without.
  - Stages S2..S7 are always normal.
- Priority: in decoy S1, drive `adv`=1 and `back`=1 → S0 genuine, `y`=8'h01, `wrap_o`=0, `dcnt_o` unchanged.
- Async reset: at S5 with `dcnt_o`=3, pulse `rst` between clock edges → outputs return to reset values before the next edge.
